// File: rtl/dino_pkg.sv
// Shared screen geometry and obstacle slot type
// for the dino runner pixel pipeline.
package dino_pkg;

  localparam int SCREEN_W   = 640;
  localparam int GROUND_ROW = 400;

  localparam int ROW_W = 9;
  localparam int COL_W = 10;
  localparam int POS_W = 11;

  typedef struct packed {
    logic             valid;
    logic [POS_W-1:0] r;
  } obs_slot_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (taps 16,14,13,11), free running
// from reset; shared source of spawn randomness.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        CLK,
  input  logic        rst,
  output logic [15:0] state
);

  localparam logic [15:0] TAPS = 16'hB400;

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = {1'b0, state_q[15:1]};
    if (state_q[0]) state_d = state_d ^ TAPS;
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/obstacle_field.sv
// Scrolling cactus field: spawn/scroll/despawn per frame,
// dinosaur collision pulse and registered pixel responder.
module obstacle_field #(
  parameter int          MAX_OBS    = 4,
  parameter int          SCREEN_W   = 640,
  parameter int          GROUND_ROW = 400,
  parameter int          OBS_W      = 16,
  parameter int          OBS_H      = 32,
  parameter int          DINO_X     = 64,
  parameter int          DINO_W     = 24,
  parameter int          MIN_GAP    = 40,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                         CLK,
  input  logic                         rst,
  input  logic                         frame_tick,
  input  logic                         restart,
  input  logic                         game_status,
  input  logic [3:0]                   speed,
  input  logic [5:0]                   dinosaur_height,
  input  logic [dino_pkg::ROW_W-1:0]   row_addr,
  input  logic [dino_pkg::COL_W-1:0]   col_addr,
  output logic                         px_obstacle,
  output logic                         hit
);

  import dino_pkg::*;

  typedef logic [POS_W-1:0] pos_t;

  localparam pos_t SPAWN_R = pos_t'(SCREEN_W + OBS_W - 1);
  localparam pos_t W_P     = pos_t'(OBS_W);
  localparam pos_t SCR_P   = pos_t'(SCREEN_W);
  localparam pos_t TOP_P   = pos_t'(GROUND_ROW - OBS_H);
  localparam pos_t BOT_P   = pos_t'(GROUND_ROW - 1);
  localparam pos_t DL_P    = pos_t'(DINO_X);
  localparam pos_t DR_P    = pos_t'(DINO_X + DINO_W - 1);
  localparam pos_t H_P     = pos_t'(OBS_H);
  localparam logic [6:0] GAP0 = 7'(MIN_GAP);

  obs_slot_t  slot_q [MAX_OBS];
  obs_slot_t  slot_d [MAX_OBS];
  pos_t       left_e [MAX_OBS];
  logic [6:0] gap_q, gap_d, gap_dec;
  logic       px_q, px_d;
  logic       hit_q, hit_d;
  logic       coll;
  logic       placed;
  logic [15:0] lfsr;
  logic       unused_lfsr;

  pos_t row11, col11, spd11;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .CLK   (CLK),
    .rst   (rst),
    .state (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:6];

  assign row11 = pos_t'(row_addr);
  assign col11 = pos_t'(col_addr);
  assign spd11 = pos_t'(speed);

  // left edge clamps to column 0 instead of wrapping
  always_comb begin
    for (int i = 0; i < MAX_OBS; i++) begin
      if (slot_q[i].r + pos_t'(1) >= W_P)
        left_e[i] = slot_q[i].r - (W_P - pos_t'(1));
      else
        left_e[i] = '0;
    end
  end

  always_comb begin
    px_d = 1'b0;
    coll = 1'b0;
    for (int i = 0; i < MAX_OBS; i++) begin
      if (slot_q[i].valid) begin
        if (row11 >= TOP_P && row11 <= BOT_P &&
            col11 >= left_e[i] && col11 <= slot_q[i].r &&
            col11 < SCR_P)
          px_d = 1'b1;
        if (slot_q[i].r >= DL_P && left_e[i] <= DR_P)
          coll = 1'b1;
      end
    end
    if (pos_t'(dinosaur_height) >= H_P) coll = 1'b0;
  end

  always_comb begin
    slot_d  = slot_q;
    gap_d   = gap_q;
    hit_d   = 1'b0;
    placed  = 1'b0;
    gap_dec = (gap_q != 7'd0) ? gap_q - 7'd1 : 7'd0;
    if (restart) begin
      for (int i = 0; i < MAX_OBS; i++) slot_d[i] = '0;
      gap_d = GAP0;
    end else if (frame_tick && game_status) begin
      hit_d = coll;
      // free slots are judged on pre-scroll validity
      for (int i = 0; i < MAX_OBS; i++) begin
        if (slot_q[i].valid) begin
          if (slot_q[i].r < spd11) slot_d[i] = '0;
          else slot_d[i].r = slot_q[i].r - spd11;
        end else if (!placed && gap_dec == 7'd0) begin
          slot_d[i].valid = 1'b1;
          slot_d[i].r     = SPAWN_R;
          placed          = 1'b1;
        end
      end
      gap_d = placed ? GAP0 + {1'b0, lfsr[5:0]} : gap_dec;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_OBS; i++) slot_q[i] <= '0;
      gap_q <= GAP0;
      px_q  <= 1'b0;
      hit_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      gap_q  <= gap_d;
      px_q   <= px_d;
      hit_q  <= hit_d;
    end
  end

  assign px_obstacle = px_q;
  assign hit         = hit_q;

endmodule

// File: tb/tb_obstacle_field.sv
// Directed bench for obstacle_field: reference model feeds a
// scoreboard of px/hit expectations plus hand-derived anchors.
module tb_obstacle_field;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       restart = 1'b0;
  logic       game_status = 1'b0;
  logic [3:0] speed = 4'd0;
  logic [5:0] dinosaur_height = 6'd40;
  logic [8:0] row_addr = 9'd0;
  logic [9:0] col_addr = 10'd0;
  logic       px_obstacle;
  logic       hit;

  obstacle_field dut (
    .CLK             (CLK),
    .rst             (rst),
    .frame_tick      (frame_tick),
    .restart         (restart),
    .game_status     (game_status),
    .speed           (speed),
    .dinosaur_height (dinosaur_height),
    .row_addr        (row_addr),
    .col_addr        (col_addr),
    .px_obstacle     (px_obstacle),
    .hit             (hit)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  string tag = "init";

  int          mv [4];
  int          mr [4];
  int          mgap;
  logic [15:0] mlfsr;

  bit q_px [$];
  bit q_hit [$];

  task automatic chk(input string name, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", name, obs, expv);
    end
  endtask

  function automatic int lo_edge(int r);
    return (r - 15 < 0) ? 0 : r - 15;
  endfunction

  function automatic bit mdl_px(int row, int col);
    bit p = 0;
    for (int i = 0; i < 4; i++)
      if (mv[i] != 0 && row >= 368 && row <= 399 &&
          col >= lo_edge(mr[i]) && col <= mr[i] && col < 640)
        p = 1;
    return p;
  endfunction

  function automatic bit mdl_coll(int h);
    bit c = 0;
    for (int i = 0; i < 4; i++)
      if (mv[i] != 0 && mr[i] >= 64 && lo_edge(mr[i]) <= 87) c = 1;
    return c && (h < 32);
  endfunction

  function automatic int n_valid();
    int n = 0;
    for (int i = 0; i < 4; i++) n += mv[i];
    return n;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 4; i++) begin mv[i] = 0; mr[i] = 0; end
    mgap  = 40;
    mlfsr = 16'hACE1;
    q_px.delete();
    q_hit.delete();
  endtask

  task automatic mdl_update();
    int fr = -1;
    if (restart) begin
      for (int i = 0; i < 4; i++) begin mv[i] = 0; mr[i] = 0; end
      mgap = 40;
    end else if (frame_tick && game_status) begin
      for (int i = 0; i < 4; i++) if (mv[i] == 0 && fr < 0) fr = i;
      for (int i = 0; i < 4; i++)
        if (mv[i] != 0) begin
          if (mr[i] < int'(speed)) begin mv[i] = 0; mr[i] = 0; end
          else mr[i] = mr[i] - int'(speed);
        end
      if (mgap > 0) mgap--;
      if (mgap == 0 && fr >= 0) begin
        mv[fr] = 1;
        mr[fr] = 655;
        mgap   = 40 + int'(mlfsr[5:0]);
      end
    end
    mlfsr = (mlfsr >> 1) ^ (mlfsr[0] ? 16'hB400 : 16'h0000);
  endtask

  task automatic step();
    q_px.push_back(mdl_px(int'(row_addr), int'(col_addr)));
    q_hit.push_back((!restart && frame_tick && game_status) ?
                    mdl_coll(int'(dinosaur_height)) : 1'b0);
    mdl_update();
    @(posedge CLK);
    #1;
    chk({tag, ":px"}, px_obstacle, q_px.pop_front());
    chk({tag, ":hit"}, hit, q_hit.pop_front());
  endtask

  task automatic rand_probe();
    int k;
    int c;
    row_addr = 9'($urandom_range(405, 360));
    k = int'($urandom_range(3, 0));
    if (mv[k] != 0 && $urandom_range(1, 0) == 1) begin
      c = mr[k] - 18 + int'($urandom_range(20, 0));
      if (c < 0) c = 0;
      col_addr = 10'(c);
    end else begin
      col_addr = 10'($urandom_range(639, 0));
    end
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    rand_probe();
    step();
    frame_tick = 1'b0;
    for (int i = 0; i < 2; i++) begin rand_probe(); step(); end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic probe(input string name, input int row, input int col,
                       input logic lit);
    row_addr = 9'(row);
    col_addr = 10'(col);
    step();
    chk(name, px_obstacle, lit);
  endtask

  task automatic frame_hit(input string name, input logic lit);
    frame_tick = 1'b1;
    step();
    chk(name, hit, lit);
    frame_tick = 1'b0;
    step();
    chk({name, "_drop"}, hit, 1'b0);
  endtask

  initial begin
    bit reached;

    tag = "reset";
    mdl_reset();
    @(posedge CLK);
    #1;
    chk("reset_px", px_obstacle, 1'b0);
    chk("reset_hit", hit, 1'b0);
    rst = 1'b0;
    probe("reset_empty", 380, 639, 1'b0);

    tag = "spawn";
    game_status = 1'b1;
    speed = 4'd4;
    frames(40);
    probe("spawn_offscreen", 380, 639, 1'b0);
    frames(1);
    probe("r651_c639", 380, 639, 1'b1);
    probe("r651_c636", 380, 636, 1'b1);
    probe("r651_c635", 380, 635, 1'b0);

    tag = "scroll";
    reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      frame();
      if (mv[0] == 0) reached = 1;
    end
    chk("despawn_reached", reached, 1'b1);
    frames(20);

    tag = "pixel";
    restart = 1'b1;
    step();
    restart = 1'b0;
    speed = 4'd5;
    frames(40);
    frames(71);
    probe("r300_368_285", 368, 285, 1'b1);
    probe("r300_399_300", 399, 300, 1'b1);
    probe("r300_367_300", 367, 300, 1'b0);
    probe("r300_400_300", 400, 300, 1'b0);
    probe("r300_380_284", 380, 284, 1'b0);
    probe("r300_380_301", 380, 301, 1'b0);

    tag = "collide";
    frames(44);
    dinosaur_height = 6'd31;
    frame_hit("hit_h31", 1'b1);
    dinosaur_height = 6'd32;
    frame_hit("hit_h32", 1'b0);

    tag = "freeze";
    game_status = 1'b0;
    dinosaur_height = 6'd31;
    for (int i = 0; i < 10; i++) frame_hit("frozen_hit", 1'b0);
    probe("frozen_c70", 380, 70, 1'b1);
    probe("frozen_c55", 380, 55, 1'b1);
    probe("frozen_c54", 380, 54, 1'b0);
    probe("frozen_c71", 380, 71, 1'b0);

    tag = "restart";
    game_status = 1'b1;
    restart = 1'b1;
    frame_hit("restart_hit", 1'b0);
    restart = 1'b0;
    dinosaur_height = 6'd40;
    probe("restart_clear", 380, 70, 1'b0);
    frames(1);
    probe("nospawn_c639", 380, 639, 1'b0);
    probe("nospawn_c635", 380, 635, 1'b0);
    frames(40);
    probe("respawn_c639", 380, 639, 1'b1);
    probe("respawn_c634", 380, 634, 1'b0);

    tag = "full";
    restart = 1'b1;
    step();
    restart = 1'b0;
    speed = 4'd0;
    reached = 0;
    for (int i = 0; i < 450 && !reached; i++) begin
      frame();
      if (n_valid() == 4) reached = 1;
    end
    chk("full_reached", reached, 1'b1);
    reached = 0;
    for (int i = 0; i < 120 && !reached; i++) begin
      frame();
      if (mgap == 0) reached = 1;
    end
    chk("gap_drained", reached, 1'b1);
    frames(10);
    speed = 4'd15;
    reached = 0;
    for (int i = 0; i < 60 && !reached; i++) begin
      frame();
      if (n_valid() == 0) reached = 1;
    end
    chk("all_despawned", reached, 1'b1);
    frames(3);
    probe("refill_c626", 380, 626, 1'b0);
    probe("refill_c620", 380, 620, 1'b1);

    tag = "async_rst";
    rst = 1'b1;
    #1;
    chk("async_px", px_obstacle, 1'b0);
    chk("async_hit", hit, 1'b0);
    @(posedge CLK);
    #1;
    rst = 1'b0;
    mdl_reset();
    speed = 4'd3;
    frames(45);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
